// File: rtl/mem_stage_pkg.sv
// Shared types and default constants for the MEM pipeline stage.
// The optional address checker is enabled with the MEM_ADDR_CHECK_EN macro.
package mem_stage_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DEPTH       = 64;
  localparam int DEF_BASE_ADDR   = 1024;
  localparam int DEF_WAIT_CYCLES = 3;

  // Word-index width for a given depth. The result is never below 1, so a
  // one-word memory still gets a legal index port.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// Data memory of DEPTH 32-bit words. Writes are synchronous, reads are
// asynchronous, and an active-low reset clears every word.
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = addr_bits(DEF_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  // Storage array: asynchronous clear, write on the clock edge when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage. It passes the EXE/MEM fields through and runs a
// fixed-latency load/store sequencer in front of data_mem.
// Handshake: ready is low while a request is in progress and not yet in DONE.
// Upstream must hold every input stable while ready is low; the stage never
// latches the request. An access is consumed on the edge where ready is high.
// Optional feature: define MEM_ADDR_CHECK_EN to add the registered addr_err
// output and to suppress accesses to bad addresses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_Enable_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] reg2_in,
  input  logic [3:0]  RD_in,
  output logic        WB_Enable,
  output logic        mem_read,
  output logic [3:0]  RD,
  output logic [31:0] ALU_result,
  output logic [31:0] mem_data,
  output logic        ready,
`ifdef MEM_ADDR_CHECK_EN
  output logic        addr_err,
`endif
  output state_t      dbg_state
);

  localparam int AW = addr_bits(DEPTH);
  localparam int CW = $clog2(WAIT_CYCLES + 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    mem_data_q, mem_data_d;
  logic           req;
  logic           is_load;
  logic           addr_bad;
  logic [AW-1:0]  word_idx;
  logic           mem_we;
  logic [31:0]    mem_rdata;

  assign WB_Enable  = WB_Enable_in;
  assign mem_read   = mem_read_in;
  assign RD         = RD_in;
  assign ALU_result = ALU_result_in;

  // Read and write together count as a store only.
  assign req      = mem_read_in | mem_write_in;
  assign is_load  = mem_read_in & ~mem_write_in;
  assign word_idx = AW'((ALU_result_in - 32'(BASE_ADDR)) >> 2);

`ifdef MEM_ADDR_CHECK_EN
  logic addr_err_q, addr_err_d;

  assign addr_bad = ({1'b0, ALU_result_in} < 33'(BASE_ADDR)) ||
                    ({1'b0, ALU_result_in} >= 33'(BASE_ADDR) + 33'(4 * DEPTH)) ||
                    (ALU_result_in[1:0] != 2'b00);

  // Error flag is high only in the DONE cycle of a bad access.
  always_comb begin
    addr_err_d = (state_d == DONE) & addr_bad;
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) addr_err_q <= 1'b0;
    else      addr_err_q <= addr_err_d;
  end

  assign addr_err = addr_err_q;
`else
  assign addr_bad = 1'b0;
`endif

  // Sequencer next state: IDLE -> BUSY (counting) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 1) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = CW'(1);
          end
        end
      end
      BUSY: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(WAIT_CYCLES - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Load data is captured on the edge that enters DONE; bad loads return 0.
  always_comb begin
    mem_data_d = mem_data_q;
    if (state_d == DONE && is_load) begin
      mem_data_d = addr_bad ? 32'd0 : mem_rdata;
    end
  end

  // Sequencer and load-data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Stores commit on the edge leaving DONE.
  assign mem_we    = (state_q == DONE) & mem_write_in & ~addr_bad;
  assign ready     = ~(req & (state_q != DONE));
  assign mem_data  = mem_data_q;
  assign dbg_state = state_q;

  data_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_data_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (word_idx),
    .wdata (reg2_in),
    .raddr (word_idx),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: instance 0 uses WAIT_CYCLES=3 and instance 1 uses
// WAIT_CYCLES=1. A transaction-level model tracks the elapsed cycles of each
// access and a word array holds the expected memory contents.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int BASE  = 1024;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wb_in[2], rd_in[2], wr_in[2];
  logic [31:0] alu_in[2], r2_in[2];
  logic [3:0]  rdst_in[2];
  logic        wb_o[2], mr_o[2], rdy[2];
  logic [3:0]  rd_o[2];
  logic [31:0] alu_o[2], md_o[2];
  state_t      st_o[2];
`ifdef MEM_ADDR_CHECK_EN
  logic        err_o[2];
  int          err_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;

  mem_stage #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst),
    .WB_Enable_in(wb_in[0]), .mem_read_in(rd_in[0]), .mem_write_in(wr_in[0]),
    .ALU_result_in(alu_in[0]), .reg2_in(r2_in[0]), .RD_in(rdst_in[0]),
    .WB_Enable(wb_o[0]), .mem_read(mr_o[0]), .RD(rd_o[0]),
    .ALU_result(alu_o[0]), .mem_data(md_o[0]), .ready(rdy[0]),
`ifdef MEM_ADDR_CHECK_EN
    .addr_err(err_o[0]),
`endif
    .dbg_state(st_o[0])
  );

  mem_stage #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst),
    .WB_Enable_in(wb_in[1]), .mem_read_in(rd_in[1]), .mem_write_in(wr_in[1]),
    .ALU_result_in(alu_in[1]), .reg2_in(r2_in[1]), .RD_in(rdst_in[1]),
    .WB_Enable(wb_o[1]), .mem_read(mr_o[1]), .RD(rd_o[1]),
    .ALU_result(alu_o[1]), .mem_data(md_o[1]), .ready(rdy[1]),
`ifdef MEM_ADDR_CHECK_EN
    .addr_err(err_o[1]),
`endif
    .dbg_state(st_o[1])
  );

  // ---------------- reference model ----------------
  int          p[2];            // edges elapsed in the current access
  logic [31:0] mdl_mem[2][DEPTH];
  logic [31:0] exp_md[2];
  logic        exp_err[2];

  function automatic int wc(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic int midx(input logic [31:0] a);
    return int'(((a - 32'(BASE)) >> 2) & 32'(DEPTH - 1));
  endfunction

  function automatic bit addr_ok(input logic [31:0] a);
`ifdef MEM_ADDR_CHECK_EN
    return (a >= 32'(BASE)) && (a < 32'(BASE + 4 * DEPTH)) && (a[1:0] == 2'b00);
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        p[k] = 0;
        exp_md[k] = '0;
        exp_err[k] = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl_mem[k][i] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        exp_err[k] = 1'b0;
        if (!(rd_in[k] | wr_in[k])) begin
          p[k] = 0;
        end else if (p[k] == wc(k)) begin
          if (wr_in[k] && addr_ok(alu_in[k])) mdl_mem[k][midx(alu_in[k])] = r2_in[k];
          p[k] = 0;
        end else begin
          p[k] = p[k] + 1;
          if (p[k] == wc(k)) begin
            exp_err[k] = !addr_ok(alu_in[k]);
            if (rd_in[k] && !wr_in[k])
              exp_md[k] = addr_ok(alu_in[k]) ? mdl_mem[k][midx(alu_in[k])] : 32'd0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        bit req;
        req = rd_in[k] | wr_in[k];
        chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(!req || p[k] == wc(k)));
        chk($sformatf("wb%0d", k), 32'(wb_o[k]), 32'(wb_in[k]));
        chk($sformatf("mem_read%0d", k), 32'(mr_o[k]), 32'(rd_in[k]));
        chk($sformatf("rd%0d", k), 32'(rd_o[k]), 32'(rdst_in[k]));
        chk($sformatf("alu%0d", k), alu_o[k], alu_in[k]);
        chk($sformatf("mem_data%0d", k), md_o[k], exp_md[k]);
`ifdef MEM_ADDR_CHECK_EN
        chk($sformatf("addr_err%0d", k), 32'(err_o[k]), 32'(exp_err[k]));
`endif
      end
`ifdef MEM_ADDR_CHECK_EN
      err_cnt += int'(err_o[0]);
`endif
    end
  end

  // ---------------- drivers ----------------
  task automatic access(input int k, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, output int lows);
    rd_in[k] = r; wr_in[k] = w; alu_in[k] = a; r2_in[k] = d;
    wb_in[k] = 1'($urandom_range(0, 1));
    rdst_in[k] = 4'($urandom_range(0, 15));
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy[k]) begin
        @(posedge clk);
        #1;
        return;
      end
      lows++;
    end
    checks++;
    errors++;
    $display("FAIL timeout%0d: ready low for %0d cycles, required %0d", k, lows, wc(k));
  endtask

  task automatic release_req(input int k);
    rd_in[k] = 1'b0;
    wr_in[k] = 1'b0;
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      release_req(k);
      wb_in[k] = 1'($urandom_range(0, 1));
      alu_in[k] = $urandom;
      rdst_in[k] = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) < 8) return 32'(BASE + 4 * $urandom_range(0, DEPTH - 1));
    return 32'($urandom_range(900, 1400));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int lows;
    for (int k = 0; k < 2; k++) begin
      wb_in[k] = 0; rd_in[k] = 0; wr_in[k] = 0;
      alu_in[k] = 0; r2_in[k] = 0; rdst_in[k] = 0;
    end
    rst = 1'b0;
    #12;
    chk("reset_state", 32'(st_o[0]), 32'(IDLE));
    chk("reset_mem_data", md_o[0], 32'd0);
    chk("reset_ready", 32'(rdy[1]), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(0, 2);

    // Non-memory op: pure pass-through, ready stays high.
    wb_in[0] = 1'b1; alu_in[0] = 32'h55; rdst_in[0] = 4'd9;
    #1;
    chk("nonmem_alu", alu_o[0], 32'h55);
    chk("nonmem_ready", 32'(rdy[0]), 32'd1);
    chk("nonmem_mem_data", md_o[0], 32'd0);
    @(posedge clk); #1;

    // Store then load with WAIT_CYCLES=3.
    access(0, 0, 1, 32'd1028, 32'hDEADBEEF, lows);
    chk("store_low_cycles", 32'(lows), 32'd3);
    access(0, 1, 0, 32'd1028, 32'd0, lows);
    chk("load_low_cycles", 32'(lows), 32'd3);
    chk("load_data", md_o[0], 32'hDEADBEEF);

    // Read and write together behave as a store.
    access(0, 1, 1, 32'd1032, 32'd7, lows);
    access(0, 1, 0, 32'd1032, 32'd0, lows);
    chk("rw_as_store", md_o[0], 32'd7);
    release_req(0);

    // WAIT_CYCLES=1: back-to-back loads.
    access(1, 0, 1, 32'd1024, 32'h11111111, lows);
    access(1, 0, 1, 32'd1028, 32'h22222222, lows);
    access(1, 1, 0, 32'd1024, 32'd0, lows);
    chk("w1_low_a", 32'(lows), 32'd1);
    chk("w1_data_a", md_o[1], 32'h11111111);
    access(1, 1, 0, 32'd1028, 32'd0, lows);
    chk("w1_low_b", 32'(lows), 32'd1);
    chk("w1_data_b", md_o[1], 32'h22222222);
    release_req(1);

    // Request dropped while busy: no write happens.
    rd_in[0] = 0; wr_in[0] = 1; alu_in[0] = 32'd1036; r2_in[0] = 32'hBAD0BAD0;
    @(posedge clk); #1;
    release_req(0);
    idle(0, 2);
    access(0, 1, 0, 32'd1036, 32'd0, lows);
    chk("aborted_store", md_o[0], 32'd0);
    release_req(0);

`ifdef MEM_ADDR_CHECK_EN
    err_cnt = 0;
    access(0, 1, 0, 32'd2000, 32'd0, lows);
    chk("bad_load_data", md_o[0], 32'd0);
    chk("bad_load_low_cycles", 32'(lows), 32'd3);
    access(0, 0, 1, 32'd1030, 32'h99, lows);
    release_req(0);
    chk("addr_err_cycles", 32'(err_cnt), 32'd2);
    access(0, 1, 0, 32'd1028, 32'd0, lows);
    chk("mem_unchanged", md_o[0], 32'hDEADBEEF);
    release_req(0);
`endif

    // Randomised mix of accesses across both instances.
    for (int it = 0; it < 150; it++) begin
      int k;
      int kind;
      k = $urandom_range(0, 1);
      kind = $urandom_range(0, 4);
      case (kind)
        0: idle(k, $urandom_range(1, 3));
        1: access(k, 1, 0, rand_addr(), 32'd0, lows);
        2: access(k, 0, 1, rand_addr(), $urandom, lows);
        3: access(k, 1, 1, rand_addr(), $urandom, lows);
        default: begin
          if (k == 0) begin
            rd_in[0] = 0; wr_in[0] = 1; alu_in[0] = rand_addr(); r2_in[0] = $urandom;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
          end
        end
      endcase
      if ($urandom_range(0, 1) == 0) release_req(k);
    end
    release_req(0);
    release_req(1);
    idle(0, 2);

    // Reset in the middle of a store, then load the same word.
    rd_in[0] = 0; wr_in[0] = 1; alu_in[0] = 32'd1040; r2_in[0] = 32'h1234;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    chk("midreset_state", 32'(st_o[0]), 32'(IDLE));
    chk("midreset_mem_data", md_o[0], 32'd0);
    rd_in[0] = 1; wr_in[0] = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk("post_reset_ready", 32'(rdy[0]), 32'd0);
    access(0, 1, 0, 32'd1040, 32'd0, lows);
    chk("midreset_load", md_o[0], 32'd0);
    release_req(0);
    idle(0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
